// File: rtl/uart_rx_fifo_if.sv
// Receive-side port bundle of the UART receiver.
//   rx              serial line, idle high
//   rx_data         head-entry data word
//   rx_parity_err   head-entry parity error flag
//   rx_frame_err    head-entry framing error flag
//   rx_valid        FIFO holds at least one word
//   rx_ready        consumer accepts the head entry
//   rx_overrun      sticky "word dropped on full FIFO"
//   clr_overrun     single-cycle clear of rx_overrun
//   rx_busy         receiver is inside a frame
// master: the receiver itself.
// slave: the line driver and consumer.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_overrun;
  logic                 clr_overrun;
  logic                 rx_busy;

  modport master (
    input  rx, rx_ready, clr_overrun,
    output rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun, rx_busy
  );

  modport slave (
    output rx, rx_ready, clr_overrun,
    input  rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun, rx_busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with a show-ahead receive FIFO.
// Each frame is a start bit, DATA_BITS data bits (LSB first), an optional
// parity bit and STOP_BITS stop bits. Every received word is stored together
// with its parity and framing error flags. A full FIFO drops incoming words
// and sets a sticky overrun flag.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   receive-side bundle (see uart_rx_fifo_if)
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.master  bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  typedef struct packed {
    logic                 frame_err;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data;
  } word_t;

  // Line synchroniser plus one history flop for edge detection.
  logic rx_meta, rx_sync, rx_prev;
  logic start_edge;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its inputs regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;

  // Receiver FSM.
  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 perr, perr_d;
  logic                 ferr, ferr_d;
  logic                 stop_idx, stop_idx_d;
  logic                 push;
  word_t                push_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      shift    <= shift_d;
      perr     <= perr_d;
      ferr     <= ferr_d;
      stop_idx <= stop_idx_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    idx_d      = idx;
    shift_d    = shift;
    perr_d     = perr;
    ferr_d     = ferr;
    stop_idx_d = stop_idx;
    push       = 1'b0;

    unique case (state)
      S_IDLE: begin
        cnt_d      = '0;
        idx_d      = '0;
        stop_idx_d = 1'b0;
        if (start_edge) begin
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = S_START;
        end
      end

      // Re-check the line at mid start bit; a high line means a glitch.
      S_START: begin
        if (cnt == CNT_MID) begin
          cnt_d   = '0;
          state_d = rx_sync ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      // Counter was aligned to mid-bit in START, so a full bit period later
      // lands mid-bit again.
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d        = '0;
          shift_d[idx] = rx_sync;
          if (idx == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = ((^shift) ^ rx_sync) != ODD_PAR;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_sync) ferr_d = 1'b1;
          if (stop_idx == STOP_LAST) begin
            push       = 1'b1;
            stop_idx_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // The framing flag includes the stop sample taken in the push cycle.
  assign push_word   = '{frame_err: ferr_d, parity_err: perr, data: shift};
  assign bus.rx_busy = (state != S_IDLE);

  // Show-ahead FIFO; pointers carry one wrap bit to tell full from empty.
  word_t            mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             empty, full, pop, wr_en;
  word_t            head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = !empty && bus.rx_ready;
  // A simultaneous pop frees the slot being written, so full does not block.
  assign wr_en = push && (!full || pop);

  // NOTE: storage has no reset; only the pointers do, and the outputs are
  // forced to zero while empty so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      bus.rx_overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      // Setting wins over a same-cycle clear.
      if (push && !wr_en)       bus.rx_overrun <= 1'b1;
      else if (bus.clr_overrun) bus.rx_overrun <= 1'b0;
    end
  end

  assign head              = mem[rd_ptr[PTR_W-1:0]];
  assign bus.rx_valid      = !empty;
  assign bus.rx_data       = empty ? '0 : head.data;
  assign bus.rx_parity_err = !empty && head.parity_err;
  assign bus.rx_frame_err  = !empty && head.frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. Four receivers at 16 clocks/bit:
//   0: 8N1 (also glitch and overrun), 1: 8E1, 2: 8N2, 3: 5O1 with own reset.
// Expected words are queued when a frame is driven and compared when the
// receiver presents them with rx_valid && rx_ready.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic clk;
  logic rst;
  logic rst_d;

  int n_vec = 0;
  int n_err = 0;

  // {frame_err, parity_err, data[8:0]}
  logic [10:0] sb [4][$];

  uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_rx_fifo_if #(.DATA_BITS(8)) if_b ();
  uart_rx_fifo_if #(.DATA_BITS(8)) if_c ();
  uart_rx_fifo_if #(.DATA_BITS(5)) if_d ();

  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));

  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  uart_rx_fifo #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(5),
                 .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_d (.clk(clk), .rst(rst_d), .bus(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       if_a.rx = v;
      1:       if_b.rx = v;
      2:       if_c.rx = v;
      default: if_d.rx = v;
    endcase
  endtask

  task automatic drive_bit(input int sel, input logic v);
    set_rx(sel, v);
    tick(CPB);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par_bit,
                            input int nstop, input logic last_stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, data[i]);
    if (has_par) drive_bit(sel, par_bit);
    for (int s = 0; s < nstop; s++) drive_bit(sel, (s == nstop - 1) ? last_stop : 1'b1);
  endtask

  task automatic expect_word(input int sel, input logic fe, input logic pe, input logic [8:0] data);
    sb[sel].push_back({fe, pe, data});
  endtask

  task automatic pop_cmp(input int sel, input logic [10:0] obs);
    logic [10:0] exp;
    if (sb[sel].size() == 0) begin
      check($sformatf("dut%0d_unexpected_word_0x%0h", sel, obs), 32'(sb[sel].size()), 32'd1);
    end else begin
      exp = sb[sel].pop_front();
      check($sformatf("dut%0d_word", sel), 32'(obs), 32'(exp));
    end
  endtask

  // Scoreboard consumers, sampled away from the active edge.
  always @(negedge clk) begin
    if (if_a.rx_valid && if_a.rx_ready)
      pop_cmp(0, {if_a.rx_frame_err, if_a.rx_parity_err, 1'b0, if_a.rx_data});
    if (if_b.rx_valid && if_b.rx_ready)
      pop_cmp(1, {if_b.rx_frame_err, if_b.rx_parity_err, 1'b0, if_b.rx_data});
    if (if_c.rx_valid && if_c.rx_ready)
      pop_cmp(2, {if_c.rx_frame_err, if_c.rx_parity_err, 1'b0, if_c.rx_data});
    if (if_d.rx_valid && if_d.rx_ready)
      pop_cmp(3, {if_d.rx_frame_err, if_d.rx_parity_err, 4'b0, if_d.rx_data});
  end

  initial begin
    bit seen;

    rst   = 1'b1;
    rst_d = 1'b1;
    if_a.rx = 1'b1; if_a.rx_ready = 1'b0; if_a.clr_overrun = 1'b0;
    if_b.rx = 1'b1; if_b.rx_ready = 1'b1; if_b.clr_overrun = 1'b0;
    if_c.rx = 1'b1; if_c.rx_ready = 1'b1; if_c.clr_overrun = 1'b0;
    if_d.rx = 1'b1; if_d.rx_ready = 1'b1; if_d.clr_overrun = 1'b0;
    tick(3);
    rst   = 1'b0;
    rst_d = 1'b0;
    tick(4);

    // Reset state.
    check("rst_valid",   32'(if_a.rx_valid),      32'd0);
    check("rst_overrun", 32'(if_a.rx_overrun),    32'd0);
    check("rst_busy",    32'(if_a.rx_busy),       32'd0);
    check("rst_data",    32'(if_a.rx_data),       32'd0);
    check("rst_perr",    32'(if_a.rx_parity_err), 32'd0);
    check("rst_ferr",    32'(if_a.rx_frame_err),  32'd0);

    // 8N1, consumer always ready.
    if_a.rx_ready = 1'b1;
    expect_word(0, 1'b0, 1'b0, 9'h0A5);
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    tick(4);
    check("a5_drained", 32'(sb[0].size()), 32'd0);
    check("a5_valid_low", 32'(if_a.rx_valid), 32'd0);

    // 8N1, consumer stalled: head must be held.
    if_a.rx_ready = 1'b0;
    expect_word(0, 1'b0, 1'b0, 9'h0A5);
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (if_a.rx_valid) seen = 1'b1;
      else tick(1);
    end
    check("hold_valid_timeout", 32'(seen), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("hold_valid", 32'(if_a.rx_valid), 32'd1);
      check("hold_data",  32'(if_a.rx_data),  32'h0A5);
      tick(1);
    end
    if_a.rx_ready = 1'b1;
    tick(2);
    check("hold_released", 32'(if_a.rx_valid), 32'd0);
    check("hold_drained",  32'(sb[0].size()),  32'd0);

    // Glitch: line low for 5 clocks only.
    set_rx(0, 1'b0);
    tick(5);
    set_rx(0, 1'b1);
    check("glitch_busy_high", 32'(if_a.rx_busy), 32'd1);
    tick(20);
    check("glitch_busy_low", 32'(if_a.rx_busy),  32'd0);
    check("glitch_no_word",  32'(if_a.rx_valid), 32'd0);

    // Overrun: five words into a four-entry FIFO with no consumer.
    if_a.rx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) expect_word(0, 1'b0, 1'b0, 9'(v));
      send_frame(0, 9'(v), 8, 1'b0, 1'b0, 1, 1'b1);
      if (v == 4) check("ovr_not_yet", 32'(if_a.rx_overrun), 32'd0);
    end
    check("ovr_set",  32'(if_a.rx_overrun), 32'd1);
    check("ovr_head", 32'(if_a.rx_data),    32'h01);
    if_a.rx_ready = 1'b1;
    tick(6);
    check("ovr_empty",   32'(if_a.rx_valid),   32'd0);
    check("ovr_drained", 32'(sb[0].size()),    32'd0);
    check("ovr_sticky",  32'(if_a.rx_overrun), 32'd1);
    if_a.clr_overrun = 1'b1;
    tick(1);
    if_a.clr_overrun = 1'b0;
    check("ovr_cleared", 32'(if_a.rx_overrun), 32'd0);

    // 8E1: good parity, then bad parity.
    expect_word(1, 1'b0, 1'b0, 9'h03C);
    send_frame(1, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1);
    expect_word(1, 1'b0, 1'b1, 9'h03C);
    send_frame(1, 9'h03C, 8, 1'b1, 1'b1, 1, 1'b1);
    tick(4);
    check("even_drained", 32'(sb[1].size()), 32'd0);

    // 8N2: bad second stop bit, line kept low, then a clean frame.
    expect_word(2, 1'b1, 1'b0, 9'h055);
    send_frame(2, 9'h055, 8, 1'b0, 1'b0, 2, 1'b0);
    tick(3 * CPB);
    check("held_low_idle", 32'(if_c.rx_busy), 32'd0);
    set_rx(2, 1'b1);
    tick(2 * CPB);
    expect_word(2, 1'b0, 1'b0, 9'h081);
    send_frame(2, 9'h081, 8, 1'b0, 1'b0, 2, 1'b1);
    tick(4);
    check("two_stop_drained", 32'(sb[2].size()), 32'd0);
    check("two_stop_idle",    32'(if_c.rx_busy), 32'd0);

    // 5O1: reset in the middle of data bit 3 of 0x13.
    drive_bit(3, 1'b0);
    drive_bit(3, 1'b1);
    drive_bit(3, 1'b1);
    drive_bit(3, 1'b0);
    set_rx(3, 1'b0);
    tick(8);
    check("mid_busy", 32'(if_d.rx_busy), 32'd1);
    rst_d = 1'b1;
    #1;
    check("mid_rst_valid",   32'(if_d.rx_valid),      32'd0);
    check("mid_rst_overrun", 32'(if_d.rx_overrun),    32'd0);
    check("mid_rst_busy",    32'(if_d.rx_busy),       32'd0);
    check("mid_rst_data",    32'(if_d.rx_data),       32'd0);
    check("mid_rst_perr",    32'(if_d.rx_parity_err), 32'd0);
    check("mid_rst_ferr",    32'(if_d.rx_frame_err),  32'd0);
    set_rx(3, 1'b1);
    tick(2);
    rst_d = 1'b0;
    tick(2 * CPB);
    // 0x1E has four ones, so odd parity bit is 1.
    expect_word(3, 1'b0, 1'b0, 9'h01E);
    send_frame(3, 9'h01E, 5, 1'b1, 1'b1, 1, 1'b1);
    tick(4);
    check("odd_drained", 32'(sb[3].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
